// File: rtl/csr_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_counter_pkg
// Description : Shared CSR addresses, modify encodings and the modify-apply
//               helper for the counter/ID/pin CSR cluster.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_counter_pkg;

  // Writable machine counter aliases
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

  // Read-only user counter aliases
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_TIME      = 12'hC01;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_TIMEH     = 12'hC81;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

  // Read-only identification registers, all reading as zero
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
  localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  // Modify command encodings; 4..7 behave like NONE
  typedef enum logic [2:0] {
    MOD_NONE  = 3'd0,
    MOD_WRITE = 3'd1,
    MOD_SET   = 3'd2,
    MOD_CLEAR = 3'd3
  } modify_e;

  // True when the command changes state
  function automatic logic modify_active(input logic [2:0] modify);
    return (modify == MOD_WRITE) || (modify == MOD_SET) || (modify == MOD_CLEAR);
  endfunction

  // New register value after applying a modify command to the old value
  function automatic logic [31:0] apply_modify(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [2:0]  modify);
    logic [31:0] result;
    result = old_val;
    case (modify)
      MOD_WRITE: result = wdata;
      MOD_SET:   result = old_val | wdata;
      MOD_CLEAR: result = old_val & ~wdata;
      default:   result = old_val;
    endcase
    return result;
  endfunction

endpackage : csr_counter_pkg
`default_nettype wire

// File: rtl/csr_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_counter_if
// Description : CSR bus between the pipeline (master) and a CSR slave.
//               Address leads read/modify/wdata by one cycle; rdata/valid
//               follow one cycle after that.
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_counter_if;
  logic        read;
  logic [2:0]  modify;
  logic [31:0] wdata;
  logic [11:0] addr;
  logic [31:0] rdata;
  logic        valid;

  modport master (
    output read, modify, wdata, addr,
    input  rdata, valid
  );

  modport slave (
    input  read, modify, wdata, addr,
    output rdata, valid
  );
endinterface : csr_counter_if
`default_nettype wire

// File: rtl/csr_counter_counter64.sv
`default_nettype none
// ============================================================================
// Module      : csr_counter64
// Description : 64-bit free-running counter with increment enable and a
//               32-bit half-select write port. A write takes priority over the
//               increment for the whole counter in that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_counter64 (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        inc_i,
  input  wire logic        wr_en_i,
  input  wire logic        wr_hi_i,
  input  wire logic [31:0] wr_data_i,
  output logic [63:0]      value_o
);

  logic [63:0] cnt_q;
  logic [63:0] cnt_d;

  // Next value: write replaces one half and suppresses the increment
  always_comb begin
    cnt_d = cnt_q;
    if (wr_en_i) begin
      if (wr_hi_i) begin
        cnt_d[63:32] = wr_data_i;
      end else begin
        cnt_d[31:0] = wr_data_i;
      end
    end else if (inc_i) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = cnt_q;

endmodule : csr_counter64
`default_nettype wire

// File: rtl/csr_counter.sv
`default_nettype none
// ============================================================================
// Module      : csr_counter
// Description : CSR slave with cycle/instret counters, identification
//               registers and a small output-pin register. Returns zero
//               rdata/valid when not addressed so it can be OR-combined with
//               other CSR slaves.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_counter
  import csr_counter_pkg::*;
#(
  parameter int unsigned KHZ        = 1000,
  parameter logic [11:0] IDS_BASE   = 12'hFC0,
  parameter logic [11:0] PINS_BASE  = 12'hBC1,
  parameter int          PINS_COUNT = 1,
  parameter logic [31:0] PINS_RESET = 32'd0
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  csr_counter_if.slave               bus,
  input  wire logic                  retired,
  output logic [PINS_COUNT-1:0]      pins
);

  logic [11:0]           addr_q;
  logic [31:0]           rdata_q;
  logic [31:0]           rdata_d;
  logic                  valid_q;
  logic                  valid_d;
  logic [PINS_COUNT-1:0] pins_q;
  logic [PINS_COUNT-1:0] pins_d;

  logic [63:0] w_cycle;
  logic [63:0] w_instret;
  logic [31:0] w_pins_ext;
  logic        w_mod_act;

  logic        w_cyc_wr;
  logic        w_cyc_hi;
  logic [31:0] w_cyc_wdata;
  logic        w_ins_wr;
  logic        w_ins_hi;
  logic [31:0] w_ins_wdata;

  assign w_mod_act = modify_active(bus.modify);

  // Address is registered so decode lines up with the following read/modify
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= bus.addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Counters: only the machine aliases are writable
  // ---------------------------------------------------------------------------
  assign w_cyc_hi    = (addr_q == ADDR_MCYCLEH);
  assign w_cyc_wr    = w_mod_act && ((addr_q == ADDR_MCYCLE) || w_cyc_hi);
  assign w_cyc_wdata = apply_modify(w_cyc_hi ? w_cycle[63:32] : w_cycle[31:0],
                                    bus.wdata, bus.modify);

  assign w_ins_hi    = (addr_q == ADDR_MINSTRETH);
  assign w_ins_wr    = w_mod_act && ((addr_q == ADDR_MINSTRET) || w_ins_hi);
  assign w_ins_wdata = apply_modify(w_ins_hi ? w_instret[63:32] : w_instret[31:0],
                                    bus.wdata, bus.modify);

  csr_counter64 u_cycle (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (1'b1),
    .wr_en_i   (w_cyc_wr),
    .wr_hi_i   (w_cyc_hi),
    .wr_data_i (w_cyc_wdata),
    .value_o   (w_cycle)
  );

  csr_counter64 u_instret (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (retired),
    .wr_en_i   (w_ins_wr),
    .wr_hi_i   (w_ins_hi),
    .wr_data_i (w_ins_wdata),
    .value_o   (w_instret)
  );

  // ---------------------------------------------------------------------------
  // Pin register: only the low PINS_COUNT bits of the operand are stored
  // ---------------------------------------------------------------------------
  generate
    if (PINS_COUNT < 32) begin : g_pins_pad
      assign w_pins_ext = {{(32 - PINS_COUNT){1'b0}}, pins_q};
    end else begin : g_pins_full
      assign w_pins_ext = pins_q;
    end
  endgenerate

  // Pin next-state from the modify command when the pin address is selected
  always_comb begin
    pins_d = pins_q;
    if (addr_q == PINS_BASE) begin
      case (bus.modify)
        MOD_WRITE: pins_d = bus.wdata[PINS_COUNT-1:0];
        MOD_SET:   pins_d = pins_q | bus.wdata[PINS_COUNT-1:0];
        MOD_CLEAR: pins_d = pins_q & ~bus.wdata[PINS_COUNT-1:0];
        default:   pins_d = pins_q;
      endcase
    end
  end

  // Pin register with reset to the configured pattern
  always_ff @(posedge clk) begin
    if (rst) begin
      pins_q <= PINS_RESET[PINS_COUNT-1:0];
    end else begin
      pins_q <= pins_d;
    end
  end

  assign pins = pins_q;

  // ---------------------------------------------------------------------------
  // Read path: decode against the registered address, values before update
  // ---------------------------------------------------------------------------
  // Read mux; unknown addresses leave both data and valid at zero
  always_comb begin
    rdata_d = '0;
    valid_d = 1'b0;
    if (bus.read) begin
      valid_d = 1'b1;
      if (addr_q == IDS_BASE) begin
        rdata_d = 32'(KHZ);
      end else if (addr_q == PINS_BASE) begin
        rdata_d = w_pins_ext;
      end else begin
        case (addr_q)
          ADDR_MCYCLE, ADDR_CYCLE, ADDR_TIME:        rdata_d = w_cycle[31:0];
          ADDR_MCYCLEH, ADDR_CYCLEH, ADDR_TIMEH:     rdata_d = w_cycle[63:32];
          ADDR_MINSTRET, ADDR_INSTRET:               rdata_d = w_instret[31:0];
          ADDR_MINSTRETH, ADDR_INSTRETH:             rdata_d = w_instret[63:32];
          ADDR_MVENDORID, ADDR_MARCHID,
          ADDR_MIMPID, ADDR_MHARTID:                 rdata_d = '0;
          default: begin
            rdata_d = '0;
            valid_d = 1'b0;
          end
        endcase
      end
    end
  end

  // Registered read response, cleared whenever no selected read occurs
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      valid_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      valid_q <= valid_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.valid = valid_q;

endmodule : csr_counter
`default_nettype wire

// File: tb/tb_csr_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_counter
// Description : Directed self-checking bench for csr_counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_counter;
  import csr_counter_pkg::*;

  logic       clk;
  logic       rst;
  logic       retired;
  logic [0:0] pins;

  int checks;
  int errors;

  logic [31:0] rd;
  logic        vl;
  logic [0:0]  p1;
  logic [0:0]  p2;

  csr_counter_if bus ();

  csr_counter #(
    .KHZ        (1000),
    .IDS_BASE   (12'hFC0),
    .PINS_BASE  (12'hBC1),
    .PINS_COUNT (1),
    .PINS_RESET (32'd0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .retired (retired),
    .pins    (pins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n edges, leaving the bench 1 time unit after the last edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One CSR transaction: address cycle, command cycle, response sampled.
  // p1 = pins during the command cycle, p2 = pins in the response cycle.
  task automatic access(input logic [11:0] a, input logic r, input logic [2:0] m,
                        input logic [31:0] wd, output logic [31:0] rdat,
                        output logic v, output logic [0:0] pin1,
                        output logic [0:0] pin2);
    bus.addr   = a;
    bus.read   = 1'b0;
    bus.modify = 3'd0;
    bus.wdata  = 32'd0;
    @(posedge clk);
    #1;
    bus.read   = r;
    bus.modify = m;
    bus.wdata  = wd;
    pin1       = pins;
    @(posedge clk);
    #1;
    rdat       = bus.rdata;
    v          = bus.valid;
    pin2       = pins;
    bus.read   = 1'b0;
    bus.modify = 3'd0;
    bus.wdata  = 32'd0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    retired    = 1'b0;
    bus.read   = 1'b0;
    bus.modify = 3'd0;
    bus.wdata  = 32'd0;
    bus.addr   = 12'd0;
    tick(3);
    rst = 1'b0;

    // Reset state
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_valid", {31'd0, bus.valid}, 32'd0);
    check("rst_pins", {31'd0, pins}, 32'd0);

    // 8 edges, then address edge takes cycle to 9, sampled at next edge
    tick(8);
    access(12'hC00, 1'b1, 3'd0, 32'd0, rd, vl, p1, p2);
    check("cycle_c00", rd, 32'd9);
    check("cycle_valid", {31'd0, vl}, 32'd1);

    access(12'hFC0, 1'b1, 3'd0, 32'd0, rd, vl, p1, p2);
    check("ids_khz", rd, 32'd1000);
    check("ids_valid", {31'd0, vl}, 32'd1);

    access(12'hF14, 1'b1, 3'd0, 32'd0, rd, vl, p1, p2);
    check("hartid", rd, 32'd0);
    check("hartid_valid", {31'd0, vl}, 32'd1);

    access(12'h123, 1'b1, 3'd0, 32'd0, rd, vl, p1, p2);
    check("unknown_rdata", rd, 32'd0);
    check("unknown_valid", {31'd0, vl}, 32'd0);

    // Carry: lo=FFFFFFFE, then hi write (lo ticks to FFFFFFFF, frozen on write)
    access(12'hB00, 1'b0, 3'd1, 32'hFFFF_FFFE, rd, vl, p1, p2);
    access(12'hB80, 1'b0, 3'd1, 32'h0000_0000, rd, vl, p1, p2);
    access(12'hB80, 1'b1, 3'd0, 32'd0, rd, vl, p1, p2);
    check("carry_hi", rd, 32'd1);
    access(12'hB00, 1'b1, 3'd0, 32'd0, rd, vl, p1, p2);
    check("carry_lo", rd, 32'd2);
    access(12'hC80, 1'b1, 3'd0, 32'd0, rd, vl, p1, p2);
    check("cycleh_alias", rd, 32'd1);

    // instret
    retired = 1'b1;
    tick(5);
    retired = 1'b0;
    access(12'hC02, 1'b1, 3'd0, 32'd0, rd, vl, p1, p2);
    check("instret5", rd, 32'd5);

    retired = 1'b1;
    access(12'hB02, 1'b0, 3'd1, 32'h0000_0100, rd, vl, p1, p2);
    retired = 1'b0;
    access(12'hB02, 1'b1, 3'd0, 32'd0, rd, vl, p1, p2);
    check("instret_wr_wins", rd, 32'h0000_0100);
    access(12'hC82, 1'b1, 3'd0, 32'd0, rd, vl, p1, p2);
    check("instret_hi", rd, 32'd0);
    access(12'hB02, 1'b0, 3'd2, 32'h0000_0003, rd, vl, p1, p2);
    access(12'hC02, 1'b1, 3'd0, 32'd0, rd, vl, p1, p2);
    check("instret_set", rd, 32'h0000_0103);
    access(12'hB02, 1'b0, 3'd3, 32'h0000_0101, rd, vl, p1, p2);
    access(12'hB02, 1'b1, 3'd0, 32'd0, rd, vl, p1, p2);
    check("instret_clear", rd, 32'h0000_0002);

    // Pins
    access(12'hBC1, 1'b0, 3'd1, 32'd1, rd, vl, p1, p2);
    check("pins_wr_n1", {31'd0, p1}, 32'd0);
    check("pins_wr_n2", {31'd0, p2}, 32'd1);
    access(12'hBC1, 1'b0, 3'd3, 32'd1, rd, vl, p1, p2);
    check("pins_clear", {31'd0, p2}, 32'd0);
    access(12'hBC1, 1'b0, 3'd2, 32'hFFFF_FFFF, rd, vl, p1, p2);
    check("pins_set", {31'd0, p2}, 32'd1);
    access(12'hBC1, 1'b1, 3'd0, 32'd0, rd, vl, p1, p2);
    check("pins_read", rd, 32'd1);
    check("pins_read_valid", {31'd0, vl}, 32'd1);
    access(12'hBC1, 1'b1, 3'd3, 32'd1, rd, vl, p1, p2);
    check("rd_mod_old", rd, 32'd1);
    check("rd_mod_new", {31'd0, p2}, 32'd0);
    access(12'hBC1, 1'b0, 3'd5, 32'd1, rd, vl, p1, p2);
    check("pins_mod5_none", {31'd0, p2}, 32'd0);

    // Read-only targets ignore writes
    access(12'hC80, 1'b0, 3'd1, 32'd5, rd, vl, p1, p2);
    access(12'hC80, 1'b1, 3'd0, 32'd0, rd, vl, p1, p2);
    check("ro_cycleh", rd, 32'd1);
    access(12'hFC0, 1'b0, 3'd1, 32'd5, rd, vl, p1, p2);
    access(12'hFC0, 1'b1, 3'd0, 32'd0, rd, vl, p1, p2);
    check("ro_ids", rd, 32'd1000);

    // Reset with cycle at 0x1_xxxx_xxxx
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    access(12'hB80, 1'b1, 3'd0, 32'd0, rd, vl, p1, p2);
    check("rst_cycle_hi", rd, 32'd0);
    access(12'hB00, 1'b1, 3'd0, 32'd0, rd, vl, p1, p2);
    check("rst_cycle_lo", rd, 32'd3);
    access(12'hC02, 1'b1, 3'd0, 32'd0, rd, vl, p1, p2);
    check("rst_instret", rd, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_csr_counter
`default_nettype wire
